// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter/sequencer granting the shared I2C byte engine to two clients.
// Optional watchdog with ERR state when I2C_ARB_TIMEOUT_EN is defined.
module i2c_bus_arbiter #(
    parameter int PAGE_BYTES = 64,
    parameter int TO_CYCLES  = 4096,
    parameter int CNT_W      = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic       byte_stb,
    output logic [6:0] byte_cnt,
    output logic       eng_wr,
    output logic       eng_rd,
    input  logic       eng_ack,
    input  logic       eng_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACTIVE,
`ifdef I2C_ARB_TIMEOUT_EN
        ERR,
`endif
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    logic       last_q, last_d;
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       stb_q, stb_d;
    logic       ewr_q, ewr_d;
    logic       erd_q, erd_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        stb_d   = 1'b0;
        ewr_d   = 1'b0;
        erd_d   = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        err_d   = 2'b00;
        wd_d    = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // on a tie, the client that did not own the engine last wins
                    owner_d = (req0 && req1) ? ~last_q : req1;
                    wr_d    = owner_d ? wr1 : wr0;
                    cnt_d   = 7'd0;
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                    ewr_d   = wr_d;
                    erd_d   = ~wr_d;
                    state_d = ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            ISSUE, ACTIVE: begin
                if (state_q == ISSUE) begin
                    state_d = ACTIVE;
                end
                if (eng_ack) begin
                    stb_d = 1'b1;
                    if (cnt_q != 7'(PAGE_BYTES)) begin
                        cnt_d = cnt_q + 7'd1;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_d = '0;
`endif
                end
                if (eng_done) begin
                    state_d         = DONE;
                    gnt_d           = 2'b00;
                    done_d[owner_q] = 1'b1;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (state_q == ACTIVE && !eng_ack) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == CNT_W'(TO_CYCLES)) begin
                        state_d        = ERR;
                        gnt_d          = 2'b00;
                        err_d[owner_q] = 1'b1;
                    end
                end
`endif
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ERR,
`endif
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 7'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            stb_q   <= 1'b0;
            ewr_q   <= 1'b0;
            erd_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= 2'b00;
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            stb_q   <= stb_d;
            ewr_q   <= ewr_d;
            erd_q   <= erd_d;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= err_d;
            wd_q    <= wd_d;
`endif
        end
    end

    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign byte_stb = stb_q;
    assign byte_cnt = cnt_q;
    assign eng_wr   = ewr_q;
    assign eng_rd   = erd_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign err0     = err_q[0];
    assign err1     = err_q[1];
`else
    assign err0     = 1'b0;
    assign err1     = 1'b0;
`endif

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Two-requester arbiter and sequencer for the shared I2C master byte engine. It grants the engine to one client at a time using round-robin. It issues a single-cycle write or read launch, then tracks per-byte acknowledge pulses and end-of-transfer from the engine. Per-client done/error/byte strobes are returned to the owner. It sits between the application-side clients (configuration writer, sample reader) and the I2C master.

## Interface
Parameters:
- PAGE_BYTES, 64, bytes per page transfer; byte_cnt saturation limit
- TO_CYCLES, 4096, watchdog limit in clk cycles without engine activity
- CNT_W, 13, watchdog counter width; must satisfy 2^CNT_W > TO_CYCLES

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  client request, level, held until done/err
- wr0 / wr1  in  1  client direction, 1 = write page, 0 = read page; sampled at grant
- gnt0 / gnt1  out  1  ownership, level, one-hot or zero
- done0 / done1  out  1  one-cycle pulse, transfer completed
- err0 / err1  out  1  one-cycle pulse, watchdog expiry (only with I2C_ARB_TIMEOUT_EN)
- byte_stb  out  1  one-cycle pulse per engine byte acknowledge, meaningful to current owner
- byte_cnt  out  7  bytes completed in current/last transfer
- eng_wr / eng_rd  out  1  one-cycle launch pulses to engine, never both high
- eng_ack  in  1  engine pulse per byte transferred
- eng_done  in  1  engine pulse at stop-condition completion

## Operation
- States: IDLE, ISSUE, ACTIVE, DONE, ERR (ERR only with I2C_ARB_TIMEOUT_EN).
- IDLE: if any req is high, select an owner. With exactly one request, grant that client. With both, grant the client not granted last. The last-owner register resets to 1, so client 0 wins the first tie. Latch the owner's wr bit, clear byte_cnt, go to ISSUE.
- ISSUE: gnt for the owner is high. eng_wr (latched wr=1) or eng_rd (wr=0) is high for exactly this cycle. Go to ACTIVE.
- ACTIVE: each eng_ack produces byte_stb and byte_cnt+1. byte_cnt saturates at PAGE_BYTES. eng_done goes to DONE.
- DONE: owner's done pulses, gnt drops, last-owner is updated, next state is IDLE.
- ERR: owner's err pulses, gnt drops, last-owner is updated, next state is IDLE.
- eng_ack and eng_done are sampled in ISSUE and ACTIVE. If both arrive in the same cycle, count the byte and finish.
- Engine inputs arriving in IDLE, DONE or ERR are ignored; no strobe, no count.
- Deasserting req while owned has no effect; the engine cannot be aborted. The transfer runs to eng_done or the watchdog.
- A req change on the non-owner is ignored until IDLE.
- Reset mid-transfer: all outputs return to reset values immediately; state goes to IDLE. The engine is reset by the same rst_n.

## Timing
- Reset values: gnt0/1=0, done0/1=0, err0/1=0, byte_stb=0, byte_cnt=0, eng_wr=0, eng_rd=0, state IDLE.
- Grant latency: req seen in IDLE at cycle N gives gnt plus eng_wr/eng_rd high at N+1, and eng_* low at N+2.
- eng_ack at cycle M gives byte_stb high and byte_cnt updated at M+1.
- eng_done at cycle D gives done pulse at D+1 with gnt low at D+1. IDLE is at D+2; the earliest next gnt is D+3.
- byte_cnt holds its final value until the next grant.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A CNT_W-bit watchdog clears on entering ISSUE and on every eng_ack.
  - It increments each ACTIVE cycle otherwise.
  - When it reaches TO_CYCLES with no eng_done that cycle: ERR, err pulse next cycle, gnt drops.
- Undefined: there is no watchdog, no ERR state, and err0/err1 are tied 0. ACTIVE waits indefinitely for eng_done.

## Test plan
- Single write: req0=1, wr0=1 → eng_wr one cycle at N+1. Engine gives 64 eng_ack then eng_done → 64 byte_stb, byte_cnt=64, done0 at D+1, gnt0 low.
- Simultaneous req0=req1=1 from reset → client 0 granted first, client 1 granted after done0, then client 0 again. Strict alternation over 4 transfers.
- Read launch: req1=1, wr1=0 → eng_rd one cycle, eng_wr stays 0, gnt1 high until done1.
- Coincident eng_ack and eng_done on byte 64 → byte_stb and done in the same cycle, byte_cnt=64. Extra eng_ack in IDLE → byte_cnt unchanged.
- Watchdog (macro on, TO_CYCLES=16): no eng_ack after launch → err0 at cycle 17 of ACTIVE, gnt0 low, IDLE. Macro off → gnt0 stays high for 1000 cycles.
- Reset asserted mid-transfer at byte 10 → all outputs 0 asynchronously. After release, a new req0 is granted at N+1 with byte_cnt=0.
